dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Multi-cycle data-memory responder that answers load/store requests issued by the pipeline's M stage.
- Accepts one request per transaction through a valid/ready handshake and latches it.
- Holds the request for a configurable number of wait states, then commits it to a word array with byte-lane enables.
- Returns one response pulse carrying the read word and an error flag.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words = 4 KiB).
- LATENCY, 2, wait-state cycles between accept and commit (legal range 0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; request accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte-lane enables; lane i = bits [8i+7:8i].
- req_wdata  input  32  store data, already lane-aligned by the CPU.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  full word read at commit; 0 for stores and errors.
- rsp_err  output  1  request rejected; no memory change.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; counter=0.
  - All memory words are cleared to 0.
  - A transaction in flight is aborted: no commit and no response.
- States:
  - IDLE: req_ready=1. On accept, latch we/addr/be/wdata, load counter=LATENCY, go to BUSY.
  - BUSY: req_ready=0. If counter!=0, decrement. If counter==0, commit on this edge and go to RESP.
  - RESP: req_ready=0; rsp_valid=1 for exactly this cycle; next edge returns to IDLE.
- Timing:
  - With accept at edge e0, commit happens at edge e(LATENCY+1).
  - rsp_valid is high between e(LATENCY+1) and e(LATENCY+2).
  - req_ready rises again at e(LATENCY+2).
  - Throughput is one transaction per LATENCY+3 cycles.
- Input changes after accept are ignored; only the latched copy is used. req_valid during BUSY or RESP is not accepted, and the requester must hold it.
- No response backpressure: the requester always consumes rsp_valid.
- Address decode:
  - word index = addr[DEPTH_LOG2+1:2].
  - Out of range if any of addr[31:DEPTH_LOG2+2] is nonzero.
- Legal be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error: out-of-range address OR illegal be (including 0000).
  - rsp_err=1 and rsp_rdata=0.
  - No write.
  - Timing identical to a normal transaction.
- Store commit: for each set lane i, mem[idx][8i+7:8i] <= wdata[8i+7:8i]; other lanes are unchanged. rsp_rdata=0, rsp_err=0.
- Load commit: rsp_rdata = mem[idx] (full word, regardless of be); rsp_err=0. Sign/zero extension belongs to the CPU.
- rsp_rdata and rsp_err hold their values until the next commit; they are only meaningful while rsp_valid=1.
- Reset asserted during BUSY before the commit edge: the write never lands and the array is zeroed anyway. After release, the block is in IDLE with req_ready=1.

Test Plan:
- Basic store/load, LATENCY=2:
  - Store we=1, addr=0x10, be=1111, wdata=0xDEADBEEF, accepted at cycle 0 -> rsp_valid high in cycle 3 only, rsp_err=0; req_ready low cycles 1-3, high in cycle 4.
  - Then load addr=0x10 -> rsp_rdata=0xDEADBEEF.
- Byte and halfword lanes:
  - Word 0x20 holds 0x11223344.
  - Store be=0100, wdata=0x00AA0000; then store be=0011, wdata=0x0000BBCC.
  - Load 0x20 -> 0x11AABBCC.
- Errors:
  - Store addr=0x00001000 with DEPTH_LOG2=10 -> rsp_err=1, no word changes.
  - Store addr=0x4, be=0110 -> rsp_err=1.
  - Store be=0000 -> rsp_err=1.
  - Each error response arrives with the same timing as a normal transaction.
- Input stability:
  - Change req_addr, req_wdata and req_be during BUSY -> commit uses the latched values.
  - req_valid held high through the transaction -> the second request is accepted only when req_ready returns.
- LATENCY=0 -> rsp_valid one cycle after the accept edge; back-to-back requests every 3 cycles.
- Reset mid-op:
  - Store to 0x8 accepted, reset driven low at cycle 1 -> no rsp_valid, outputs go to reset values immediately, and a load from 0x8 after release returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the M stage: accepts one load/store,
// waits LATENCY cycles, commits to a byte-laned word array and pulses a response.
module dm_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [3:0]            counter;
    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [3:0]            lat_be;
    logic [31:0]           lat_wdata;
    logic [31:0]           mem [DEPTH];
    logic                  accept;
    logic                  commit;
    logic                  be_legal;
    logic                  in_range;
    logic                  req_error;
    logic [DEPTH_LOG2-1:0] word_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (counter == 4'd0) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Only the latched copy of the request is used after accept, so the
    // requester may change its inputs freely while we are busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter   <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            counter   <= 4'(LATENCY);
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end else if (state == BUSY && counter != 4'd0) begin
            counter <= counter - 4'd1;
        end
    end

    always_comb begin
        word_idx = lat_addr[DEPTH_LOG2+1:2];
        in_range = (lat_addr >> (DEPTH_LOG2 + 2)) == 32'd0;
        case (lat_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
        req_error = !in_range || !be_legal;
    end

    // Response data is held until the next commit; it is only meaningful
    // while rsp_valid is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= req_error;
            rsp_rdata <= (!req_error && !lat_we) ? mem[word_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= 32'd0;
            end
        end else if (commit && !req_error && lat_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lat_be[lane]) begin
                    mem[word_idx][8*lane +: 8] <= lat_wdata[8*lane +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: two instances (LATENCY 2 and 0) driven with
// directed and random traffic, checked against a word-array reference model.
module tb_dm_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr [2];
    logic [3:0]  req_be [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    int          cyc;
    int          checks;
    int          errors;
    int          last_acc [2];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] model_mem [2][1024];
    logic [3:0]  legal_be [7];

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // 4 KiB of memory: anything at or beyond byte 4096 is rejected.
    function automatic logic ref_error(input logic [31:0] addr, input logic [3:0] be);
        logic ok_be;
        ok_be = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (be == legal_be[i]) ok_be = 1'b1;
        end
        return (addr >= 32'h0000_1000) || !ok_be;
    endfunction

    function automatic int queue_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic apply_stimulus(input int d, input logic we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata,
                                  input bit chk_gap);
        int          waited;
        int          acc;
        int          idx;
        exp_t        e;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_be[d]    = be;
        req_wdata[d] = wdata;
        waited = 0;
        while (!req_ready[d] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout dut=%0d actual=ready_low required=ready_high", d);
            req_valid[d] = 1'b0;
        end else begin
            acc = cyc + 1;
            if (chk_gap) check_output("accept_gap", acc - last_acc[d], lat_of(d) + 3);
            last_acc[d] = acc;
            idx     = int'(addr[11:2]);
            e.err   = ref_error(addr, be);
            e.rdata = 32'd0;
            e.due   = acc + lat_of(d) + 1;
            if (!e.err) begin
                if (we) model_mem[d][idx] = merge_lanes(model_mem[d][idx], wdata, be);
                else    e.rdata = model_mem[d][idx];
            end
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            @(posedge clk);
        end
    endtask

    // Called right after apply_stimulus: drops valid and checks when ready returns.
    task automatic wait_done(input int d);
        int waited;
        @(negedge clk);
        req_valid[d] = 1'b0;
        waited = 0;
        while (!(req_ready[d] && queue_size(d) == 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!(req_ready[d] && queue_size(d) == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout dut=%0d actual=pending required=idle", d);
        end else begin
            check_output("ready_return", cyc, last_acc[d] + lat_of(d) + 2);
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            check_output("reset_req_ready", req_ready[d], 1);
            check_output("reset_rsp_valid", rsp_valid[d], 0);
            check_output("reset_rsp_rdata", rsp_rdata[d], 0);
            check_output("reset_rsp_err",   rsp_err[d],   0);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 1024; w++) model_mem[d][w] = 32'd0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    always @(negedge clk) begin : monitor_a
        exp_t e;
        if (reset && rsp_valid[0]) begin
            check_output("ready_low_in_resp_a", req_ready[0], 0);
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp_a actual=rsp_valid required=no_response");
            end else begin
                e = exp_q0.pop_front();
                check_output("rsp_timing_a", cyc, e.due);
                check_output("rsp_rdata_a", rsp_rdata[0], e.rdata);
                check_output("rsp_err_a", rsp_err[0], e.err);
            end
        end
    end

    always @(negedge clk) begin : monitor_b
        exp_t e;
        if (reset && rsp_valid[1]) begin
            check_output("ready_low_in_resp_b", req_ready[1], 0);
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp_b actual=rsp_valid required=no_response");
            end else begin
                e = exp_q1.pop_front();
                check_output("rsp_timing_b", cyc, e.due);
                check_output("rsp_rdata_b", rsp_rdata[1], e.rdata);
                check_output("rsp_err_b", rsp_err[1], e.err);
            end
        end
    end

    initial begin
        bit          chained;
        logic [31:0] addr;
        logic [3:0]  be;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        last_acc = '{0, 0};
        clear_model();
        reset     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = 32'd0;
            req_be[d]    = 4'd0;
            req_wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        $display("[TB] basic store/load");
        apply_stimulus(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        wait_done(0);

        $display("[TB] byte and halfword lanes");
        apply_stimulus(0, 1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b1, 32'h20, 4'b0011, 32'h0000BBCC, 1'b0);
        wait_done(0);
        check_output("lane_merge_model", model_mem[0][8], 32'h11AABBCC);
        apply_stimulus(0, 1'b0, 32'h20, 4'b0001, 32'h0, 1'b0);
        wait_done(0);

        $display("[TB] error cases");
        apply_stimulus(0, 1'b1, 32'h00001000, 4'b1111, 32'hFFFFFFFF, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b1, 32'h4, 4'b0110, 32'hFFFFFFFF, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b1, 32'h4, 4'b0000, 32'hFFFFFFFF, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h4, 4'b1111, 32'h0, 1'b0);
        wait_done(0);

        $display("[TB] input stability");
        apply_stimulus(0, 1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_addr[0]  = 32'h34;
        req_be[0]    = 4'b0001;
        req_wdata[0] = 32'h12345678;
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h30, 4'b1111, 32'h0, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h34, 4'b1111, 32'h0, 1'b0);
        wait_done(0);

        $display("[TB] held valid");
        apply_stimulus(0, 1'b1, 32'h40, 4'b1100, 32'h5A5A0000, 1'b0);
        apply_stimulus(0, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b1);
        wait_done(0);

        $display("[TB] latency zero back-to-back");
        apply_stimulus(1, 1'b1, 32'h100, 4'b1111, 32'hA0B0C0D0, 1'b0);
        apply_stimulus(1, 1'b1, 32'h100, 4'b1000, 32'hEE000000, 1'b1);
        apply_stimulus(1, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b1);
        apply_stimulus(1, 1'b1, 32'h2000, 4'b1111, 32'h1, 1'b1);
        wait_done(1);

        $display("[TB] random traffic");
        for (int d = 0; d < 2; d++) begin
            chained = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 9) == 0) addr = $urandom;
                else addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                if ($urandom_range(0, 9) < 7) be = legal_be[$urandom_range(0, 6)];
                else be = 4'($urandom_range(0, 15));
                apply_stimulus(d, 1'($urandom_range(0, 1)), addr, be, $urandom, chained);
                if ($urandom_range(0, 2) == 0 && n != 39) begin
                    chained = 1'b1;
                end else begin
                    chained = 1'b0;
                    wait_done(d);
                end
            end
        end

        $display("[TB] reset mid-operation");
        apply_stimulus(0, 1'b1, 32'h8, 4'b1111, 32'hA5A5A5A5, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b0, 32'h8, 4'b1111, 32'h0, 1'b0);
        wait_done(0);
        apply_stimulus(0, 1'b1, 32'h8, 4'b1111, 32'h77777777, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_output("post_reset_ready", req_ready[0], 1);
        apply_stimulus(0, 1'b0, 32'h8, 4'b1111, 32'h0, 1'b0);
        wait_done(0);

        repeat (5) @(negedge clk);
        check_output("queue_drain", exp_q0.size() + exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
